// File: rtl/scan_seq_pkg.sv
// Shared encodings and widths for the decoder scan sequencer.
package scan_seq_pkg;

    localparam int SLOT_W = 2;
    localparam int NSLOTS = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/next_slot_pick.sv
// Finds the next enabled slot after cur, searching cyclically upward.
module next_slot_pick
    import scan_seq_pkg::*;
(
    input  logic [SLOT_W-1:0] cur,
    input  logic [NSLOTS-1:0] mask,
    output logic [SLOT_W-1:0] nxt,
    output logic              wrap,
    output logic              none
);

    logic              found;
    logic [SLOT_W-1:0] idx;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NSLOTS; i++) begin
            idx = cur + SLOT_W'(i);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
        none = (mask == '0);
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scans a 2-to-4 decoder through the enabled slots with blank/dwell timing.
module decoder_scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int DWELL = 8,
    parameter int BLANK = 2,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] mask,
    output logic       a,
    output logic       b,
    output logic       e,
    output logic       busy,
    output logic       slot_done,
    output logic       frame_done
);

    localparam logic [CW-1:0] DWELL_LD  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD  = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam bit            HAS_BLANK = (BLANK > 0);

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [SLOT_W-1:0] slot, slot_n;
    logic [SLOT_W-1:0] pend_slot;
    logic              pend_go;
    logic              last_n, go_n;

    logic [SLOT_W-1:0] start_nxt, next_nxt;
    logic              start_none, next_none, next_wrap;
    logic              unused_start_wrap;

    next_slot_pick u_start (
        .cur  ('1),
        .mask (mask),
        .nxt  (start_nxt),
        .wrap (unused_start_wrap),
        .none (start_none)
    );

    // Looks ahead from the slot about to enter its final DRIVE cycle so
    // frame_done can be registered alongside slot_done.
    next_slot_pick u_next (
        .cur  (slot_n),
        .mask (mask),
        .nxt  (next_nxt),
        .wrap (next_wrap),
        .none (next_none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            slot  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            slot  <= slot_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        slot_n  = slot;
        unique case (state)
            S_IDLE: begin
                slot_n = '0;
                cnt_n  = '0;
                if (run && !start_none) begin
                    slot_n  = start_nxt;
                    state_n = HAS_BLANK ? S_BLANK : S_DRIVE;
                    cnt_n   = HAS_BLANK ? BLANK_LD : DWELL_LD;
                end
            end
            S_BLANK: begin
                if (cnt == '0) begin
                    state_n = S_DRIVE;
                    cnt_n   = DWELL_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_DRIVE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (pend_go) begin
                    slot_n  = pend_slot;
                    state_n = HAS_BLANK ? S_BLANK : S_DRIVE;
                    cnt_n   = HAS_BLANK ? BLANK_LD : DWELL_LD;
                end else begin
                    slot_n  = '0;
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                slot_n  = '0;
            end
        endcase
        last_n = (state_n == S_DRIVE) && (cnt_n == '0);
        go_n   = run && !next_none;
    end

    // run/mask are captured on entry to the final DRIVE cycle; that decision
    // drives both frame_done and the following boundary transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            e          <= 1'b0;
            busy       <= 1'b0;
            slot_done  <= 1'b0;
            frame_done <= 1'b0;
            pend_slot  <= '0;
            pend_go    <= 1'b0;
        end else begin
            e          <= (state_n == S_DRIVE);
            busy       <= (state_n != S_IDLE);
            slot_done  <= last_n;
            frame_done <= last_n && (!go_n || next_wrap);
            if (last_n) begin
                pend_slot <= next_nxt;
                pend_go   <= go_n;
            end
        end
    end

    assign a = slot[1];
    assign b = slot[0];

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer (default and BLANK=0/DWELL=3 builds).
module tb_decoder_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, f_run;
    logic [3:0] mask, f_mask;
    logic       a, b, e, busy, slot_done, frame_done;
    logic       fa, fb, fe, fbusy, fslot_done, fframe_done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0] slot;
        logic       frame;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t x;

    always #5 clk = ~clk;

    decoder_scan_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mask       (mask),
        .a          (a),
        .b          (b),
        .e          (e),
        .busy       (busy),
        .slot_done  (slot_done),
        .frame_done (frame_done)
    );

    decoder_scan_sequencer #(.DWELL(3), .BLANK(0), .CW(8)) dut_fast (
        .clk        (clk),
        .rst        (rst),
        .run        (f_run),
        .mask       (f_mask),
        .a          (fa),
        .b          (fb),
        .e          (fe),
        .busy       (fbusy),
        .slot_done  (fslot_done),
        .frame_done (fframe_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        run   = 1'b0;
        f_run = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; run = 1'b0; f_run = 1'b0; mask = 4'b1111; f_mask = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if ({a, b, e, busy, slot_done, frame_done} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_idle k=%0d got %b exp 000000", k,
                         {a, b, e, busy, slot_done, frame_done});
            end
            vectors++;
            if ({fa, fb, fe, fbusy, fslot_done, fframe_done} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_idle_fast k=%0d got %b exp 000000", k,
                         {fa, fb, fe, fbusy, fslot_done, fframe_done});
            end
        end
        run = 1'b1; mask = 4'b0000; f_run = 1'b1; f_mask = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if ({busy, e, fbusy, fe} !== 4'b0) begin
                miscompares++;
                $display("FAIL empty_mask k=%0d got %b exp 0000", k, {busy, e, fbusy, fe});
            end
        end
        run = 1'b0; f_run = 1'b0;
    endtask

    task automatic test_full_scan;
        logic [1:0] es;
        logic       ee;
        do_reset();
        mask = 4'b1111;
        run  = 1'b1;
        sb.push_back('{2'd0, 1'b0, 10});
        sb.push_back('{2'd1, 1'b0, 20});
        sb.push_back('{2'd2, 1'b0, 30});
        sb.push_back('{2'd3, 1'b1, 40});
        sb.push_back('{2'd0, 1'b0, 50});
        for (int k = 1; k <= 50; k++) begin
            tick();
            es = 2'(((k - 1) / 10) % 4);
            ee = ((k - 1) % 10) >= 2;
            vectors++;
            if ({a, b, e, busy} !== {es, ee, 1'b1}) begin
                miscompares++;
                $display("FAIL full_scan_abe k=%0d got %b exp %b", k, {a, b, e, busy}, {es, ee, 1'b1});
            end
            if (slot_done) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL full_scan_extra_pulse k=%0d got slot_done exp none", k);
                end else begin
                    x = sb.pop_front();
                    if (k != x.cyc || {a, b} !== x.slot || frame_done !== x.frame) begin
                        miscompares++;
                        $display("FAIL full_scan_slot got cyc=%0d slot=%0d frame=%b exp cyc=%0d slot=%0d frame=%b",
                                 k, {a, b}, frame_done, x.cyc, x.slot, x.frame);
                    end
                end
            end else if (frame_done) begin
                vectors++;
                miscompares++;
                $display("FAIL full_scan_lone_frame k=%0d got 1 exp 0", k);
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL full_scan_missing got %0d left exp 0", sb.size());
        end
        sb.delete();
        do_reset();
    endtask

    task automatic test_masked_skip;
        logic [1:0] es;
        do_reset();
        f_mask = 4'b1010;
        f_run  = 1'b1;
        sb.push_back('{2'd1, 1'b0, 3});
        sb.push_back('{2'd3, 1'b1, 6});
        sb.push_back('{2'd1, 1'b0, 9});
        sb.push_back('{2'd3, 1'b1, 12});
        for (int k = 1; k <= 12; k++) begin
            tick();
            es = (((k - 1) / 3) % 2 != 0) ? 2'd3 : 2'd1;
            vectors++;
            if ({fa, fb, fe, fbusy} !== {es, 2'b11}) begin
                miscompares++;
                $display("FAIL masked_skip_abe k=%0d got %b exp %b", k, {fa, fb, fe, fbusy}, {es, 2'b11});
            end
            if (fslot_done) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL masked_skip_extra_pulse k=%0d got slot_done exp none", k);
                end else begin
                    x = sb.pop_front();
                    if (k != x.cyc || {fa, fb} !== x.slot || fframe_done !== x.frame) begin
                        miscompares++;
                        $display("FAIL masked_skip_slot got cyc=%0d slot=%0d frame=%b exp cyc=%0d slot=%0d frame=%b",
                                 k, {fa, fb}, fframe_done, x.cyc, x.slot, x.frame);
                    end
                end
            end
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL masked_skip_missing got %0d left exp 0", sb.size());
        end
        sb.delete();
        do_reset();
    endtask

    task automatic test_single_stop;
        logic [1:0] es;
        logic       ee, eb;
        do_reset();
        mask = 4'b0100;
        run  = 1'b1;
        sb.push_back('{2'd2, 1'b1, 10});
        for (int k = 1; k <= 14; k++) begin
            tick();
            eb = (k <= 10);
            ee = (k >= 3) && (k <= 10);
            es = eb ? 2'd2 : 2'd0;
            vectors++;
            if ({a, b, e, busy} !== {es, ee, eb}) begin
                miscompares++;
                $display("FAIL single_stop_abe k=%0d got %b exp %b", k, {a, b, e, busy}, {es, ee, eb});
            end
            if (slot_done) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL single_stop_extra_pulse k=%0d got slot_done exp none", k);
                end else begin
                    x = sb.pop_front();
                    if (k != x.cyc || {a, b} !== x.slot || frame_done !== x.frame) begin
                        miscompares++;
                        $display("FAIL single_stop_slot got cyc=%0d slot=%0d frame=%b exp cyc=%0d slot=%0d frame=%b",
                                 k, {a, b}, frame_done, x.cyc, x.slot, x.frame);
                    end
                end
            end
            if (k == 6) run = 1'b0;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL single_stop_missing got %0d left exp 0", sb.size());
        end
        sb.delete();
        do_reset();
    endtask

    task automatic test_mask_change;
        logic [1:0] es;
        logic       ee;
        do_reset();
        mask = 4'b1111;
        run  = 1'b1;
        sb.push_back('{2'd0, 1'b0, 10});
        sb.push_back('{2'd1, 1'b1, 20});
        sb.push_back('{2'd0, 1'b1, 30});
        for (int k = 1; k <= 30; k++) begin
            tick();
            es = (k > 10 && k <= 20) ? 2'd1 : 2'd0;
            ee = ((k - 1) % 10) >= 2;
            vectors++;
            if ({a, b, e} !== {es, ee}) begin
                miscompares++;
                $display("FAIL mask_change_abe k=%0d got %b exp %b", k, {a, b, e}, {es, ee});
            end
            if (slot_done) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL mask_change_extra_pulse k=%0d got slot_done exp none", k);
                end else begin
                    x = sb.pop_front();
                    if (k != x.cyc || {a, b} !== x.slot || frame_done !== x.frame) begin
                        miscompares++;
                        $display("FAIL mask_change_slot got cyc=%0d slot=%0d frame=%b exp cyc=%0d slot=%0d frame=%b",
                                 k, {a, b}, frame_done, x.cyc, x.slot, x.frame);
                    end
                end
            end
            if (k == 15) mask = 4'b0001;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL mask_change_missing got %0d left exp 0", sb.size());
        end
        sb.delete();
        do_reset();
    endtask

    task automatic test_reset_mid_drive;
        do_reset();
        mask = 4'b0100;
        run  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if ({a, b, e, slot_done} !== {2'd2, (k >= 3), 1'b0}) begin
                miscompares++;
                $display("FAIL mid_drive_pre k=%0d got %b exp %b", k, {a, b, e, slot_done}, {2'd2, (k >= 3), 1'b0});
            end
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({a, b, e, busy, slot_done, frame_done} !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_drive_reset got %b exp 000000", {a, b, e, busy, slot_done, frame_done});
        end
        rst = 1'b0;
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({a, b, e, busy, slot_done, frame_done} !== 6'b0) begin
                miscompares++;
                $display("FAIL mid_drive_after k=%0d got %b exp 000000", k,
                         {a, b, e, busy, slot_done, frame_done});
            end
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; f_run = 1'b0; mask = 4'b0000; f_mask = 4'b0000;
        test_reset();
        test_full_scan();
        test_masked_skip();
        test_single_stop();
        test_mask_change();
        test_reset_mid_drive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Sequential front end for the 2-to-4 decoder (decoder2to4). It cycles a 2-bit slot index through the enabled slots and drives the decoder's a (MSB), b (LSB) and e inputs.
- Each enabled slot is driven for a fixed dwell time. Between slots there is an optional blanking gap with e low, for ghost-free multiplexing of displays, LED banks and similar loads.
- Slots whose mask bit is clear are skipped. The block reports the end of each slot and the end of each full frame.

Parameters:
- DWELL, 8, cycles e is held high per slot; legal range 1..2^CW-1.
- BLANK, 2, cycles e is held low before each slot; legal range 0..2^CW-1.
- CW, 8, width of the internal dwell/blank counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  enables scanning; level-sensitive.
- mask  in  4  bit i=1 enables slot i, where slot index = {a,b}.
- a  out  1  slot index MSB, drives decoder a.
- b  out  1  slot index LSB, drives decoder b.
- e  out  1  decoder enable.
- busy  out  1  high whenever the state is not IDLE.
- slot_done  out  1  one-cycle pulse on the last DRIVE cycle of a slot.
- frame_done  out  1  one-cycle pulse on the last DRIVE cycle of the final enabled slot in a frame.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Every output is registered.
- Reset values: a=0, b=0, e=0, busy=0, slot_done=0, frame_done=0; state=IDLE; counter=0.
- rst asserted at any point, including mid-slot, forces the reset values at the next edge. No partial slot completes.
- States: IDLE, BLANK, DRIVE; 2-bit encoding.
- IDLE:
  - Outputs: e=0, a/b=0.
  - If run=1 and mask!=0 at edge t, the slot becomes the lowest set bit of mask, visible on a/b at t+1.
  - Next state is BLANK if BLANK>0, otherwise DRIVE, so e=1 at t+1.
  - If run=1 and mask=0, the block stays in IDLE.
- BLANK:
  - e=0; a/b already show the upcoming slot.
  - Lasts exactly BLANK cycles, then DRIVE.
- DRIVE:
  - e=1 for exactly DWELL cycles; a/b are stable throughout.
  - slot_done=1 on the final DRIVE cycle.
- Slot boundary (final DRIVE cycle):
  - run and mask are sampled at this edge.
  - Next slot = first set mask bit, searching cyclically upward from current+1.
  - Wrap condition: next index <= current index. This includes the case where only one slot is enabled (next = current).
  - On wrap, frame_done=1 on the same cycle as slot_done.
  - If run=0 or mask=0 at the boundary, go to IDLE: a/b return to 0, e=0, and frame_done pulses along with slot_done.
  - Otherwise go to BLANK, or directly to DRIVE if BLANK=0.
- Mid-slot changes:
  - Deasserting run never truncates a slot; the current slot always finishes its DWELL.
  - mask changes mid-slot have no effect until the next boundary.
- Timing:
  - Frame period = N_enabled × (BLANK+DWELL) cycles.
  - Defaults with mask=4'b1111: period is 40 cycles.
- Counter: counts down from DWELL-1 or BLANK-1 and is reloaded on every state entry. It never wraps within a state.
- e is never high while a/b are changing: a/b update only on a cycle where e is 0 next, or on a BLANK=0 DRIVE->DRIVE boundary. In that case a/b and e change on the same edge, and the decoder output switches cleanly because both are registered.

Decomposition:
- Package scan_seq_pkg:
  - state encoding constants S_IDLE=2'd0, S_BLANK=2'd1, S_DRIVE=2'd2;
  - slot index width constant (2).
- One combinational sub-module, next_slot_pick:
  - inputs: cur[1:0], mask[3:0];
  - outputs: nxt[1:0], wrap, none (mask==0).
  - Used at the boundary. IDLE uses it with cur=3, so that nxt is the lowest set bit.
- The top level holds the FSM, the counter and the output registers.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then run=0 for 10 cycles -> a=b=e=busy=0 and no pulses throughout.
- Full scan, defaults: mask=1111, run=1 -> {a,b} = 0,1,2,3,0,…; e low 2 / high 8 per slot; slot_done every 10 cycles; frame_done at cycle 40 from start.
- Masked skip: mask=1010, BLANK=0, DWELL=3 -> slots 1,3,1,3; e stays high continuously; frame_done on every second slot_done.
- Single slot with stop: mask=0100, run dropped at mid-DWELL -> slot 2 completes all 8 DRIVE cycles; slot_done and frame_done pulse together; then IDLE with busy=0.
- Mask change: mask 1111 -> 0001 during slot 1 -> slot 1 finishes, wrap to slot 0, frame_done pulses at the slot-1 boundary.
- Reset mid-DRIVE: rst asserted at DRIVE cycle 4 of slot 2 -> next edge gives e=0, a=b=0, busy=0, and no slot_done pulse.
